// File: rtl/ct_ifu_bht_pkg.sv
// Shared types and constants for the BHT prediction-array controller.
package ct_ifu_bht_pkg;

   localparam int BHT_IDX_W  = 10;
   localparam int BHT_DATA_W = 64;
   localparam int BHT_SEL_W  = 5;

   // Every 2-bit counter weakly-not-taken (2'b01).
   localparam logic [BHT_DATA_W-1:0] BHT_INIT_PATTERN = 64'h5555_5555_5555_5555;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      INV    = 2'd1,
      UPD_RD = 2'd2,
      UPD_WR = 2'd3
   } bht_state_e;

endpackage

// File: rtl/ct_ifu_bht_sat_cnt.sv
// Saturating 2-bit branch counter step: taken counts up to 3, not-taken down to 0.
module ct_ifu_bht_sat_cnt (
   input  logic [1:0] old_cnt,
   input  logic       taken,
   output logic [1:0] new_cnt
);

   // Step the counter, holding at the ends instead of wrapping.
   always_comb begin
      new_cnt = old_cnt;
      if (taken) begin
         if (old_cnt != 2'b11) new_cnt = old_cnt + 2'd1;
      end else begin
         if (old_cnt != 2'b00) new_cnt = old_cnt - 2'd1;
      end
   end

endmodule

// File: rtl/ct_ifu_bht_pre_array_ctrl.sv
// Controller for the BHT prediction array: invalidate sweep, predict reads,
// and read-modify-write counter updates on one single-port array.
module ct_ifu_bht_pre_array_ctrl
   import ct_ifu_bht_pkg::*;
(
   input  logic                  forever_cpuclk,
   input  logic                  cpurst,
   input  logic                  inv_req,
   input  logic                  rd_vld,
   input  logic [BHT_IDX_W-1:0]  rd_index,
   output logic                  rd_rdy,
   output logic                  rd_data_vld,
   output logic [BHT_DATA_W-1:0] rd_data,
   input  logic                  upd_vld,
   input  logic [BHT_IDX_W-1:0]  upd_index,
   input  logic [BHT_SEL_W-1:0]  upd_sel,
   input  logic                  upd_taken,
   output logic                  upd_rdy,
   output logic                  inv_busy,
   output logic                  bht_pre_array_clk_en,
   output logic                  bht_pred_array_cen_b,
   output logic                  bht_pred_array_gwen,
   output logic [BHT_IDX_W-1:0]  bht_pred_array_index,
   output logic [BHT_DATA_W-1:0] bht_pred_array_din,
   output logic [BHT_DATA_W-1:0] bht_pred_bwen,
   input  logic [BHT_DATA_W-1:0] bht_pre_data_out
);

   bht_state_e             state_q;
   bht_state_e             state_d;
   logic [BHT_IDX_W-1:0]   sweep_cnt_q;
   logic [BHT_IDX_W-1:0]   upd_index_q;
   logic [BHT_SEL_W-1:0]   upd_sel_q;
   logic                   upd_taken_q;
   logic                   rd_data_vld_q;
   logic                   rd_accept;
   logic                   upd_accept;
   logic [5:0]             slot_shift;
   logic [1:0]             old_cnt;
   logic [1:0]             new_cnt;

   assign rd_accept  = rd_vld & rd_rdy;
   assign upd_accept = upd_vld & upd_rdy;
   assign slot_shift = {upd_sel_q, 1'b0};
   assign old_cnt    = bht_pre_data_out[slot_shift +: 2];

   assign rd_data              = bht_pre_data_out;
   assign rd_data_vld          = rd_data_vld_q;
   assign inv_busy             = (state_q == INV);
   assign bht_pre_array_clk_en = ~bht_pred_array_cen_b;

   ct_ifu_bht_sat_cnt u_sat_cnt (
      .old_cnt (old_cnt),
      .taken   (upd_taken_q),
      .new_cnt (new_cnt)
   );

   // State register; reset always lands in INV so a full sweep follows.
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) state_q <= INV;
      else        state_q <= state_d;
   end

   // Sweep address counts through INV and sits at zero otherwise.
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst)                sweep_cnt_q <= '0;
      else if (state_q == INV)   sweep_cnt_q <= sweep_cnt_q + 1'b1;
      else                       sweep_cnt_q <= '0;
   end

   // Capture the update request so the array read and write see stable fields.
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         upd_index_q <= '0;
         upd_sel_q   <= '0;
         upd_taken_q <= 1'b0;
      end else if (upd_accept) begin
         upd_index_q <= upd_index;
         upd_sel_q   <= upd_sel;
         upd_taken_q <= upd_taken;
      end
   end

   // Array Q is valid the cycle after a read access, so flag it then.
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) rd_data_vld_q <= 1'b0;
      else        rd_data_vld_q <= rd_accept;
   end

   // Next-state and array-side drive; an idle array sees a fully quiet interface.
   always_comb begin
      state_d              = state_q;
      rd_rdy               = 1'b0;
      upd_rdy              = 1'b0;
      bht_pred_array_cen_b = 1'b1;
      bht_pred_array_gwen  = 1'b1;
      bht_pred_array_index = '0;
      bht_pred_array_din   = '0;
      bht_pred_bwen        = '1;
      case (state_q)
         IDLE: begin
            if (inv_req) begin
               state_d = INV;
            end else begin
               rd_rdy  = 1'b1;
               upd_rdy = 1'b1;
               if (rd_vld) begin
                  bht_pred_array_cen_b = 1'b0;
                  bht_pred_array_index = rd_index;
               end
               if (upd_vld) state_d = UPD_RD;
            end
         end
         INV: begin
            bht_pred_array_cen_b = 1'b0;
            bht_pred_array_gwen  = 1'b0;
            bht_pred_array_index = sweep_cnt_q;
            bht_pred_array_din   = BHT_INIT_PATTERN;
            bht_pred_bwen        = '0;
            if (&sweep_cnt_q) state_d = IDLE;
         end
         UPD_RD: begin
            bht_pred_array_cen_b = 1'b0;
            bht_pred_array_index = upd_index_q;
            state_d              = UPD_WR;
         end
         UPD_WR: begin
            bht_pred_array_cen_b = 1'b0;
            bht_pred_array_gwen  = 1'b0;
            bht_pred_array_index = upd_index_q;
            bht_pred_array_din   = {{(BHT_DATA_W-2){1'b0}}, new_cnt} << slot_shift;
            bht_pred_bwen        = ~({{(BHT_DATA_W-2){1'b0}}, 2'b11} << slot_shift);
            state_d              = IDLE;
         end
         default: state_d = INV;
      endcase
   end

endmodule

// File: tb/tb_ct_ifu_bht_pre_array_ctrl.sv
// Bench for the BHT prediction-array controller with a behavioural array model
// and a queue-based scoreboard for read returns and update writes.
module tb_ct_ifu_bht_pre_array_ctrl;

   logic        clk;
   logic        cpurst;
   logic        inv_req;
   logic        rd_vld;
   logic [9:0]  rd_index;
   logic        rd_rdy;
   logic        rd_data_vld;
   logic [63:0] rd_data;
   logic        upd_vld;
   logic [9:0]  upd_index;
   logic [4:0]  upd_sel;
   logic        upd_taken;
   logic        upd_rdy;
   logic        inv_busy;
   logic        clk_en;
   logic        cen_b;
   logic        gwen;
   logic [9:0]  arr_index;
   logic [63:0] arr_din;
   logic [63:0] arr_bwen;
   logic [63:0] arr_q;

   logic [63:0] mem [0:1023];

   typedef struct {
      logic [9:0]  idx;
      logic [63:0] bwen;
      logic [63:0] din_m;
   } wr_exp_t;

   logic [63:0] rd_exp_q [$];
   wr_exp_t     wr_exp_q [$];

   int checks = 0;
   int errors = 0;

   localparam logic [63:0] PAT = 64'h5555_5555_5555_5555;

   ct_ifu_bht_pre_array_ctrl dut (
      .forever_cpuclk       (clk),
      .cpurst               (cpurst),
      .inv_req              (inv_req),
      .rd_vld               (rd_vld),
      .rd_index             (rd_index),
      .rd_rdy               (rd_rdy),
      .rd_data_vld          (rd_data_vld),
      .rd_data              (rd_data),
      .upd_vld              (upd_vld),
      .upd_index            (upd_index),
      .upd_sel              (upd_sel),
      .upd_taken            (upd_taken),
      .upd_rdy              (upd_rdy),
      .inv_busy             (inv_busy),
      .bht_pre_array_clk_en (clk_en),
      .bht_pred_array_cen_b (cen_b),
      .bht_pred_array_gwen  (gwen),
      .bht_pred_array_index (arr_index),
      .bht_pred_array_din   (arr_din),
      .bht_pred_bwen        (arr_bwen),
      .bht_pre_data_out     (arr_q)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural single-port array: masked write, or registered read.
   always @(posedge clk) begin
      if (!cen_b) begin
         if (!gwen) mem[arr_index] <= (mem[arr_index] & arr_bwen) | (arr_din & ~arr_bwen);
         else       arr_q <= mem[arr_index];
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic rv, input logic [9:0] ri, input logic uv,
                                input logic [9:0] ui, input logic [4:0] us,
                                input logic ut, input logic inv);
      @(negedge clk);
      rd_vld    = rv;
      rd_index  = ri;
      upd_vld   = uv;
      upd_index = ui;
      upd_sel   = us;
      upd_taken = ut;
      inv_req   = inv;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic doRead(input logic [9:0] idx, input logic [63:0] exp);
      applyStimulus(1'b1, idx, 1'b0, 10'd0, 5'd0, 1'b0, 1'b0);
      #1 checkOutput("rd_rdy_at_read", {63'd0, rd_rdy}, 64'd1);
      rd_exp_q.push_back(exp);
      idleCycles(2);
   endtask

   task automatic doUpdate(input logic [9:0] idx, input logic [4:0] sel, input logic taken,
                           input logic with_read, input logic [63:0] rd_exp,
                           input logic inv_at_rd, input logic [63:0] bwen_exp,
                           input logic [63:0] din_exp);
      wr_exp_t w;
      w.idx = idx; w.bwen = bwen_exp; w.din_m = din_exp;
      wr_exp_q.push_back(w);
      applyStimulus(with_read, idx, 1'b1, idx, sel, taken, 1'b0);
      #1 checkOutput("upd_rdy_T", {63'd0, upd_rdy}, 64'd1);
      if (with_read) rd_exp_q.push_back(rd_exp);
      applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 5'd0, 1'b0, inv_at_rd);
      #1 checkOutput("upd_rdy_T1", {63'd0, upd_rdy}, 64'd0);
      applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 5'd0, 1'b0, 1'b0);
      #1 checkOutput("upd_rdy_T2", {63'd0, upd_rdy}, 64'd0);
      checkOutput("inv_busy_T2", {63'd0, inv_busy}, 64'd0);
      applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 5'd0, 1'b0, 1'b0);
      #1 checkOutput("upd_rdy_T3", {63'd0, upd_rdy}, 64'd1);
      checkOutput("inv_busy_T3", {63'd0, inv_busy}, 64'd0);
   endtask

   // Counts busy cycles starting from the current (already busy) sample point.
   task automatic waitSweep(input int exp_cycles, input string name);
      int n = 0;
      while (inv_busy === 1'b1 && n < 3000) begin
         n++;
         @(negedge clk);
         #1;
      end
      checkOutput(name, 64'(n), 64'(exp_cycles));
   endtask

   // Scoreboard monitor: pops expected read returns and update writes, tracks sweeps.
   initial begin
      int sw_cnt = 0;
      int sw_idx = 0;
      int sw_bad = 0;
      logic prev_busy = 1'b0;
      wr_exp_t w;
      forever begin
         @(negedge clk);
         #2;
         checkOutput("clk_en_vs_cen_b", {63'd0, clk_en}, {63'd0, ~cen_b});
         if (cpurst) begin
            sw_cnt = 0; sw_idx = 0; sw_bad = 0; prev_busy = 1'b0;
         end else begin
            if (rd_data_vld) begin
               if (rd_exp_q.size() == 0) checkOutput("rd_unexpected", 64'd1, 64'd0);
               else checkOutput("rd_data", rd_data, rd_exp_q.pop_front());
            end
            if (inv_busy) begin
               sw_cnt++;
               if (arr_index !== 10'(sw_idx) || arr_din !== PAT || arr_bwen !== 64'd0 ||
                   gwen !== 1'b0 || cen_b !== 1'b0 || rd_rdy !== 1'b0 || upd_rdy !== 1'b0)
                  sw_bad++;
               sw_idx++;
            end else if (!cen_b && !gwen) begin
               if (wr_exp_q.size() == 0) checkOutput("wr_unexpected", 64'd1, 64'd0);
               else begin
                  w = wr_exp_q.pop_front();
                  checkOutput("wr_index", {54'd0, arr_index}, {54'd0, w.idx});
                  checkOutput("wr_bwen", arr_bwen, w.bwen);
                  checkOutput("wr_din_slot", arr_din & ~arr_bwen, w.din_m);
               end
            end
            if (prev_busy && !inv_busy) begin
               checkOutput("sweep_writes", 64'(sw_cnt), 64'd1024);
               checkOutput("sweep_bad_cycles", 64'(sw_bad), 64'd0);
               sw_cnt = 0; sw_idx = 0; sw_bad = 0;
            end
            prev_busy = inv_busy;
         end
      end
   end

   // Directed stimulus sequence.
   initial begin
      logic found;
      cpurst = 1'b1; inv_req = 1'b0; rd_vld = 1'b0; rd_index = '0;
      upd_vld = 1'b0; upd_index = '0; upd_sel = '0; upd_taken = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_inv_busy", {63'd0, inv_busy}, 64'd1);
      checkOutput("rst_rd_data_vld", {63'd0, rd_data_vld}, 64'd0);
      checkOutput("rst_rd_rdy", {63'd0, rd_rdy}, 64'd0);
      checkOutput("rst_upd_rdy", {63'd0, upd_rdy}, 64'd0);

      @(negedge clk);
      cpurst = 1'b0;
      #1 checkOutput("sweep_start_index", {54'd0, arr_index}, 64'd0);
      waitSweep(1024, "sweep_len_after_reset");

      idleCycles(1);
      #1;
      checkOutput("idle_cen_b", {63'd0, cen_b}, 64'd1);
      checkOutput("idle_gwen", {63'd0, gwen}, 64'd1);
      checkOutput("idle_bwen", arr_bwen, 64'hFFFF_FFFF_FFFF_FFFF);
      checkOutput("idle_index", {54'd0, arr_index}, 64'd0);
      checkOutput("idle_din", arr_din, 64'd0);
      checkOutput("idle_clk_en", {63'd0, clk_en}, 64'd0);

      doRead(10'd5, PAT);

      doUpdate(10'd5, 5'd3, 1'b1, 1'b0, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF3F, 64'h80);
      doUpdate(10'd5, 5'd3, 1'b1, 1'b0, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF3F, 64'hC0);
      doRead(10'd5, 64'h5555_5555_5555_55D5);
      doUpdate(10'd5, 5'd3, 1'b1, 1'b0, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF3F, 64'hC0);
      doRead(10'd5, 64'h5555_5555_5555_55D5);

      doUpdate(10'd7, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
      doUpdate(10'd7, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
      doRead(10'd7, 64'h5555_5555_5555_5554);

      doUpdate(10'd9, 5'd1, 1'b1, 1'b1, PAT, 1'b0, 64'hFFFF_FFFF_FFFF_FFF3, 64'h8);
      doRead(10'd9, 64'h5555_5555_5555_5559);

      doUpdate(10'd11, 5'd2, 1'b0, 1'b0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFCF, 64'h0);
      doRead(10'd11, 64'h5555_5555_5555_5545);

      doUpdate(10'd20, 5'd31, 1'b1, 1'b0, 64'd0, 1'b0, 64'h3FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
      doRead(10'd20, 64'h9555_5555_5555_5555);

      applyStimulus(1'b1, 10'd5, 1'b1, 10'd5, 5'd0, 1'b1, 1'b1);
      #1;
      checkOutput("inv_req_rd_rdy", {63'd0, rd_rdy}, 64'd0);
      checkOutput("inv_req_upd_rdy", {63'd0, upd_rdy}, 64'd0);
      checkOutput("inv_req_cen_b", {63'd0, cen_b}, 64'd1);
      applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 5'd0, 1'b0, 1'b0);
      #1;
      waitSweep(1024, "sweep_len_after_inv_req");
      doRead(10'd5, PAT);

      applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 5'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 5'd0, 1'b0, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         #1;
         if (inv_busy && arr_index == 10'd300) found = 1'b1;
         else @(negedge clk);
      end
      checkOutput("reached_index_300", {63'd0, found}, 64'd1);
      cpurst = 1'b1;
      repeat (2) @(negedge clk);
      #1 checkOutput("midsweep_rst_busy", {63'd0, inv_busy}, 64'd1);
      @(negedge clk);
      cpurst = 1'b0;
      #1 checkOutput("restart_index", {54'd0, arr_index}, 64'd0);
      waitSweep(1024, "sweep_len_after_midrst");
      doRead(10'd20, PAT);

      idleCycles(3);
      checkOutput("rd_queue_drained", 64'(rd_exp_q.size()), 64'd0);
      checkOutput("wr_queue_drained", 64'(wr_exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ct_ifu_bht_pre_array_ctrl.md
CT_IFU_BHT_PRE_ARRAY_CTRL -- requirements
Module: ct_ifu_bht_pre_array_ctrl

Interface
REQ-001 SHALL have ports: forever_cpuclk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: cpurst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: inv_req  in  1  pulse, request a full-array invalidate sweep.
REQ-004 SHALL have ports: rd_vld  in  1; rd_index  in  10; rd_rdy  out  1. Predict-read handshake.
REQ-005 SHALL have ports: rd_data_vld  out  1; rd_data  out  64. Read return.
REQ-006 SHALL have ports: upd_vld  in  1; upd_index  in  10; upd_sel  in  5 (counter slot 0..31); upd_taken  in  1; upd_rdy  out  1.
REQ-007 SHALL have ports: inv_busy  out  1  high while the sweep runs.
REQ-008 SHALL have array-side outputs: bht_pre_array_clk_en 1; bht_pred_array_cen_b 1 (active-low); bht_pred_array_gwen 1 (active-low write); bht_pred_array_index 10; bht_pred_array_din 64; bht_pred_bwen 64 (active-low per bit).
REQ-009 SHALL have array-side input: bht_pre_data_out  in  64  array Q, valid one cycle after a read access.

Function
REQ-010 SHALL implement states IDLE, INV, UPD_RD, UPD_WR.
REQ-011 Array outputs with no access: cen_b=1, gwen=1, bwen=all ones, index=0, din=0.
REQ-012 bht_pre_array_clk_en SHALL equal ~bht_pred_array_cen_b in every cycle.
REQ-013 INV: one write per cycle, index = sweep counter 0..1023, gwen=0, bwen=0, din=64'h5555_5555_5555_5555 (all counters weakly-not-taken 2'b01).
REQ-014 INV SHALL return to IDLE the cycle after writing index 1023; inv_busy=1 exactly while in INV.
REQ-015 IDLE priority: inv_req > read/update acceptance; inv_req in IDLE moves to INV next cycle, rd_rdy and upd_rdy=0 that cycle.
REQ-016 inv_req while in INV, UPD_RD or UPD_WR SHALL be ignored (not queued).
REQ-017 rd_rdy=1 and upd_rdy=1 only in IDLE with inv_req=0.
REQ-018 Read accept (rd_vld & rd_rdy): same-cycle array read, cen_b=0, gwen=1, index=rd_index.
REQ-019 rd_data_vld SHALL be registered, high exactly one cycle after each accepted read; rd_data = bht_pre_data_out (combinational).
REQ-020 Update accept (upd_vld & upd_rdy) SHALL latch index/sel/taken and go to UPD_RD; may coincide with a read accept (read serviced, sees pre-update data).
REQ-021 UPD_RD: array read of latched index; next state UPD_WR.
REQ-022 UPD_WR: old = Q[2*sel+1:2*sel]; new = taken ? min(old+1,3) : max(old-1,0); write cen_b=0, gwen=0, bwen bits [2*sel+1:2*sel]=0, all others 1, din carries new in that slot; next state IDLE.
REQ-023 Counter arithmetic SHALL saturate; 2'b11 taken stays 2'b11, 2'b00 not-taken stays 2'b00.
REQ-024 Update latency: accept cycle T, read T+1, write T+2, upd_rdy high again T+3.

Reset
REQ-025 Reset SHALL force state INV, sweep counter 0, rd_data_vld=0, latched update fields 0; a full sweep SHALL follow every reset.
REQ-026 Reset mid-INV or mid-update SHALL abandon the operation; no partial write after reset deasserts except the restarted sweep.

Structure
REQ-027 Package ct_ifu_bht_pkg SHALL hold: state enum, BHT_IDX_W=10, BHT_DATA_W=64, BHT_INIT_PATTERN.
REQ-028 Saturating 2-bit update SHALL be sub-module ct_ifu_bht_sat_cnt (old, taken -> new).
REQ-029 Controller SHALL hold no SRAM model; it connects port-for-port to the existing prediction array wrapper.

Verification
REQ-030 Reset -> 1024 consecutive writes, index 0..1023, din 64'h5555..., bwen=0; inv_busy low at cycle 1025; rd_rdy low throughout.
REQ-031 Post-sweep read index 5 -> rd_data_vld one cycle later, rd_data=64'h5555_5555_5555_5555.
REQ-032 Update index 5 sel 3 taken twice -> slot bits [7:6] go 01->10->11; third taken keeps 11; bwen=64'hFFFF_FFFF_FFFF_FF3F on writes.
REQ-033 Update index 7 sel 0 not-taken twice from 01 -> 00 then stays 00.
REQ-034 rd_vld and upd_vld same cycle, same index -> read returns old value; upd_rdy low for 2 cycles; later read shows updated slot.
REQ-035 inv_req during UPD_RD -> ignored, update completes; reset asserted mid-sweep at index 300 -> sweep restarts at 0.
